shield_ctrl: RTL and testbench

- Upstream of the game control FSM; produces its `is_shielded` input.
- Also consumes the FSM's `donkey_hit` pulse to grant a short post-hit invulnerability window.
- Manages a collectable shield power-up with timed active, cooldown and ready phases, counted in frames.
- Provides a blink-gated visibility flag to the Donkey sprite draw stage.

---
 rtl/shield_ctrl.sv | 157 +++++++++++++++
 tb/tb_shield_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shield_ctrl.sv
// Shield power-up controller: READY/ACTIVE/COOLDOWN phases counted in frames, post-hit grace window, blink-gated overlay.
// Optional build macro SHIELD_EXTEND_EN: a pickup while ACTIVE refreshes the shield instead of being ignored.
module shield_ctrl #(
  parameter int SHIELD_FRAMES   = 180,
  parameter int COOLDOWN_FRAMES = 300,
  parameter int GRACE_FRAMES    = 60,
  parameter int WARN_FRAMES     = 60,
  parameter int BLINK_PERIOD    = 8,
  parameter int CNT_W           = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_en,
  input  logic             frame_tick,
  input  logic             shield_pickup,
  input  logic             donkey_hit,
  output logic             is_shielded,
  output logic             shield_ready,
  output logic             shield_visible,
  output logic [CNT_W-1:0] shield_frames_left
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_READY    = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam int GR_W  = $clog2(GRACE_FRAMES + 1);
  localparam int DIV_W = $clog2(BLINK_PERIOD);

  localparam logic [CNT_W-1:0] SHIELD_LD   = CNT_W'(SHIELD_FRAMES);
  localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] WARN_LIM    = CNT_W'(WARN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [GR_W-1:0]  GRACE_LD    = GR_W'(GRACE_FRAMES);
  localparam logic [GR_W-1:0]  GR_ONE      = GR_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GR_W-1:0]  grace, grace_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic             blink, blink_nx;
  logic             enter_active;
  logic             shielded_nx, warn_nx, ready_nx, visible_nx;
  logic [CNT_W-1:0] left_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    grace_nx     = grace;
    div_nx       = div;
    blink_nx     = blink;
    enter_active = 1'b0;

    // A fresh hit always reloads, even on a tick cycle.
    if (donkey_hit)
      grace_nx = GRACE_LD;
    else if (frame_tick && grace != '0)
      grace_nx = grace - GR_ONE;

    case (state)
      ST_OFF: state_nx = ST_READY;
      ST_READY: begin
        if (shield_pickup) begin
          state_nx     = ST_ACTIVE;
          cnt_nx       = SHIELD_LD;
          enter_active = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (frame_tick) begin
          if (cnt == CNT_ONE) begin
            state_nx = ST_COOLDOWN;
            cnt_nx   = COOLDOWN_LD;
          end else if (cnt != '0) begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
`ifdef SHIELD_EXTEND_EN
        if (shield_pickup) begin
          state_nx     = ST_ACTIVE;
          cnt_nx       = SHIELD_LD;
          enter_active = 1'b1;
        end
`endif
      end
      ST_COOLDOWN: begin
        if (frame_tick) begin
          if (cnt == CNT_ONE) begin
            state_nx = ST_READY;
            cnt_nx   = '0;
          end else if (cnt != '0) begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
      end
      default: state_nx = ST_OFF;
    endcase

    // Divider is a power of two, so it wraps naturally; toggle on the all-ones step.
    if (enter_active || donkey_hit) begin
      div_nx   = '0;
      blink_nx = 1'b0;
    end else if (frame_tick) begin
      div_nx = div + DIV_ONE;
      if (div == '1)
        blink_nx = ~blink;
    end

    if (!game_en) begin
      state_nx = ST_OFF;
      cnt_nx   = '0;
      grace_nx = '0;
      div_nx   = '0;
      blink_nx = 1'b0;
    end

    shielded_nx = (state_nx == ST_ACTIVE) || (grace_nx != '0);
    warn_nx     = ((state_nx == ST_ACTIVE) && (cnt_nx <= WARN_LIM)) ||
                  ((grace_nx != '0) && (state_nx != ST_ACTIVE));
    visible_nx  = shielded_nx && (!warn_nx || !blink_nx);
`ifdef SHIELD_EXTEND_EN
    ready_nx    = (state_nx == ST_READY) || (state_nx == ST_ACTIVE);
`else
    ready_nx    = (state_nx == ST_READY);
`endif
    left_nx     = ((state_nx == ST_ACTIVE) || (state_nx == ST_COOLDOWN)) ? cnt_nx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_OFF;
      cnt                <= '0;
      grace              <= '0;
      div                <= '0;
      blink              <= 1'b0;
      is_shielded        <= 1'b0;
      shield_ready       <= 1'b0;
      shield_visible     <= 1'b0;
      shield_frames_left <= '0;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      grace              <= grace_nx;
      div                <= div_nx;
      blink              <= blink_nx;
      is_shielded        <= shielded_nx;
      shield_ready       <= ready_nx;
      shield_visible     <= visible_nx;
      shield_frames_left <= left_nx;
    end
  end

endmodule

// File: tb/tb_shield_ctrl.sv
// Bench for shield_ctrl: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_shield_ctrl;
  localparam int S  = 4;
  localparam int C  = 3;
  localparam int G  = 2;
  localparam int W  = 2;
  localparam int BP = 2;
  localparam int CW = 9;

  localparam int P_OFF = 0, P_READY = 1, P_ACTIVE = 2, P_COOL = 3;

  logic clk = 0;
  logic rst = 1;
  logic game_en = 0;
  logic frame_tick = 0;
  logic shield_pickup = 0;
  logic donkey_hit = 0;
  logic is_shielded, shield_ready, shield_visible;
  logic [CW-1:0] shield_frames_left;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_phase = P_OFF, m_left = 0, m_grace = 0, m_frames = 0, m_blink = 0;
  int exp_sh = 0, exp_rdy = 0, exp_vis = 0, exp_left = 0;

  shield_ctrl #(
    .SHIELD_FRAMES(S), .COOLDOWN_FRAMES(C), .GRACE_FRAMES(G),
    .WARN_FRAMES(W), .BLINK_PERIOD(BP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .frame_tick(frame_tick),
    .shield_pickup(shield_pickup), .donkey_hit(donkey_hit),
    .is_shielded(is_shielded), .shield_ready(shield_ready),
    .shield_visible(shield_visible), .shield_frames_left(shield_frames_left)
  );

  always #5 clk = ~clk;

  task automatic model_update(input int p, input int h, input int t);
    int entering;
    int warn;
    entering = 0;
    if (rst || !game_en) begin
      m_phase = P_OFF; m_left = 0; m_grace = 0; m_frames = 0; m_blink = 0;
    end else begin
      if (h) m_grace = G;
      else if (t && m_grace > 0) m_grace = m_grace - 1;
      if (m_phase == P_OFF) begin
        m_phase = P_READY;
      end else if (m_phase == P_READY) begin
        if (p) begin m_phase = P_ACTIVE; m_left = S; entering = 1; end
      end else if (m_phase == P_ACTIVE) begin
        if (t) begin
          if (m_left == 1) begin m_phase = P_COOL; m_left = C; end
          else m_left = m_left - 1;
        end
`ifdef SHIELD_EXTEND_EN
        if (p) begin m_phase = P_ACTIVE; m_left = S; entering = 1; end
`endif
      end else begin
        if (t) begin
          if (m_left == 1) begin m_phase = P_READY; m_left = 0; end
          else m_left = m_left - 1;
        end
      end
      if (entering || h) begin
        m_frames = 0; m_blink = 0;
      end else if (t) begin
        m_frames = m_frames + 1;
        if (m_frames == BP) begin m_frames = 0; m_blink = 1 - m_blink; end
      end
    end
    exp_sh = (m_phase == P_ACTIVE || m_grace > 0) ? 1 : 0;
    warn = ((m_phase == P_ACTIVE && m_left <= W) || (m_grace > 0 && m_phase != P_ACTIVE)) ? 1 : 0;
    exp_vis = (exp_sh && (!warn || m_blink == 0)) ? 1 : 0;
`ifdef SHIELD_EXTEND_EN
    exp_rdy = (m_phase == P_READY || m_phase == P_ACTIVE) ? 1 : 0;
`else
    exp_rdy = (m_phase == P_READY) ? 1 : 0;
`endif
    exp_left = (m_phase == P_ACTIVE || m_phase == P_COOL) ? m_left : 0;
  endtask

  task automatic step(input logic p, input logic h, input logic t);
    shield_pickup = p; donkey_hit = h; frame_tick = t;
    @(posedge clk);
    model_update(int'(p), int'(h), int'(t));
    #1;
    shield_pickup = 0; donkey_hit = 0; frame_tick = 0;
  endtask

  task automatic restart();
    game_en = 0; step(0, 0, 0);
    game_en = 1; step(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; game_en = 0;
    step(0, 0, 0); step(0, 0, 0);
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL reset_shielded: got %0b expected 0", is_shielded); end
    tests++; if (shield_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b expected 0", shield_ready); end
    tests++; if (shield_visible !== 1'b0) begin fails++; $display("FAIL reset_visible: got %0b expected 0", shield_visible); end
    tests++; if (shield_frames_left !== 9'd0) begin fails++; $display("FAIL reset_left: got %0d expected 0", shield_frames_left); end
    rst = 0; game_en = 1;
    step(0, 0, 0);
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL reset_to_ready: got %0b expected 1", shield_ready); end
  endtask

  task automatic test_pickup_cycle();
    restart();
    step(1, 0, 0);
    tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL pickup_shielded: got %0b expected 1", is_shielded); end
    tests++; if (shield_frames_left !== 9'd4) begin fails++; $display("FAIL pickup_left: got %0d expected 4", shield_frames_left); end
    tests++; if (shield_ready !== 1'b0) begin fails++; $display("FAIL pickup_ready: got %0b expected 0", shield_ready); end
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1);
      tests++; if (shield_frames_left !== CW'(4 - k)) begin fails++; $display("FAIL active_count: got %0d expected %0d", shield_frames_left, 4 - k); end
      tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL active_shielded: got %0b expected 1", is_shielded); end
    end
    step(0, 0, 1);
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL expire_shielded: got %0b expected 0", is_shielded); end
    tests++; if (shield_frames_left !== 9'd3) begin fails++; $display("FAIL expire_left: got %0d expected 3", shield_frames_left); end
    tests++; if (shield_ready !== 1'b0) begin fails++; $display("FAIL expire_ready: got %0b expected 0", shield_ready); end
    step(0, 0, 1); step(0, 0, 1);
    tests++; if (shield_ready !== 1'b0) begin fails++; $display("FAIL cooldown_ready: got %0b expected 0", shield_ready); end
    step(0, 0, 1);
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL cooldown_done_ready: got %0b expected 1", shield_ready); end
    tests++; if (shield_frames_left !== 9'd0) begin fails++; $display("FAIL cooldown_done_left: got %0d expected 0", shield_frames_left); end
  endtask

  task automatic test_cooldown_pickup();
    restart();
    step(1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1);
    step(1, 0, 0);
    tests++; if (shield_frames_left !== 9'd3) begin fails++; $display("FAIL cd_pickup_left: got %0d expected 3", shield_frames_left); end
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL cd_pickup_shielded: got %0b expected 0", is_shielded); end
    step(0, 0, 1);
    step(1, 0, 1);
    tests++; if (shield_frames_left !== 9'd1) begin fails++; $display("FAIL cd_pickup_tick_left: got %0d expected 1", shield_frames_left); end
    step(0, 0, 1);
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL cd_end_ready: got %0b expected 1", shield_ready); end
  endtask

`ifdef SHIELD_EXTEND_EN
  task automatic test_extend();
    restart();
    step(1, 0, 0); step(0, 0, 1); step(0, 0, 1);
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL extend_ready: got %0b expected 1", shield_ready); end
    step(1, 0, 0);
    tests++; if (shield_frames_left !== 9'd4) begin fails++; $display("FAIL extend_left: got %0d expected 4", shield_frames_left); end
  endtask
`endif

  task automatic test_grace();
    restart();
    step(0, 1, 0);
    tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL grace_rise: got %0b expected 1", is_shielded); end
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL grace_ready: got %0b expected 1", shield_ready); end
    step(0, 0, 1);
    tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL grace_hold: got %0b expected 1", is_shielded); end
    step(0, 0, 1);
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL grace_fall: got %0b expected 0", is_shielded); end
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL grace_still_ready: got %0b expected 1", shield_ready); end
    step(0, 1, 1);
    step(0, 0, 1);
    tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL grace_load_wins: got %0b expected 1", is_shielded); end
    step(0, 0, 1);
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL grace_load_wins_fall: got %0b expected 0", is_shielded); end
  endtask

  task automatic test_blink();
    restart();
    step(1, 0, 0);
    step(0, 0, 1);
    tests++; if (shield_visible !== 1'b1) begin fails++; $display("FAIL blink_cnt3: got %0b expected 1", shield_visible); end
    step(0, 0, 0);
    tests++; if (shield_visible !== 1'b1) begin fails++; $display("FAIL blink_cnt3_steady: got %0b expected 1", shield_visible); end
    step(0, 1, 0);
    step(0, 0, 1);
    tests++; if (shield_visible !== 1'b1) begin fails++; $display("FAIL blink_cnt2: got %0b expected 1", shield_visible); end
    step(0, 0, 1);
    tests++; if (shield_visible !== 1'b0) begin fails++; $display("FAIL blink_cnt1: got %0b expected 0", shield_visible); end
    tests++; if (is_shielded !== 1'b1) begin fails++; $display("FAIL blink_cnt1_shielded: got %0b expected 1", is_shielded); end
    step(0, 0, 1);
    tests++; if (shield_visible !== 1'b0) begin fails++; $display("FAIL blink_expired: got %0b expected 0", shield_visible); end
  endtask

  task automatic test_game_en_drop();
    restart();
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1);
    tests++; if (shield_frames_left !== 9'd3) begin fails++; $display("FAIL drop_pre_left: got %0d expected 3", shield_frames_left); end
    game_en = 0;
    step(0, 0, 0);
    tests++; if ({is_shielded, shield_ready, shield_visible} !== 3'b000) begin fails++; $display("FAIL drop_flags: got %b expected 000", {is_shielded, shield_ready, shield_visible}); end
    tests++; if (shield_frames_left !== 9'd0) begin fails++; $display("FAIL drop_left: got %0d expected 0", shield_frames_left); end
    game_en = 1;
    step(0, 0, 0);
    tests++; if (shield_ready !== 1'b1) begin fails++; $display("FAIL reenable_ready: got %0b expected 1", shield_ready); end
    tests++; if (is_shielded !== 1'b0) begin fails++; $display("FAIL reenable_shielded: got %0b expected 0", is_shielded); end
  endtask

  task automatic test_rst_cooldown();
    restart();
    step(1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1);
    tests++; if (shield_frames_left !== 9'd3) begin fails++; $display("FAIL rstcd_pre_left: got %0d expected 3", shield_frames_left); end
    rst = 1;
    step(0, 0, 0);
    tests++; if ({is_shielded, shield_ready, shield_visible} !== 3'b000) begin fails++; $display("FAIL rstcd_flags: got %b expected 000", {is_shielded, shield_ready, shield_visible}); end
    tests++; if (shield_frames_left !== 9'd0) begin fails++; $display("FAIL rstcd_left: got %0d expected 0", shield_frames_left); end
    rst = 0; game_en = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1);
      tests++; if ({is_shielded, shield_ready, shield_frames_left} !== 11'd0) begin fails++; $display("FAIL disabled_pickup: got %b expected 0", {is_shielded, shield_ready, shield_frames_left}); end
    end
    game_en = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      game_en = ($urandom_range(0, 99) != 0);
      step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 11) == 0),
           logic'($urandom_range(0, 2) == 0));
      tests++; if (is_shielded !== exp_sh[0]) begin fails++; $display("FAIL rand_shielded cyc %0d: got %0b expected %0d", n, is_shielded, exp_sh); end
      tests++; if (shield_ready !== exp_rdy[0]) begin fails++; $display("FAIL rand_ready cyc %0d: got %0b expected %0d", n, shield_ready, exp_rdy); end
      tests++; if (shield_visible !== exp_vis[0]) begin fails++; $display("FAIL rand_visible cyc %0d: got %0b expected %0d", n, shield_visible, exp_vis); end
      tests++; if (shield_frames_left !== CW'(exp_left)) begin fails++; $display("FAIL rand_left cyc %0d: got %0d expected %0d", n, shield_frames_left, exp_left); end
    end
    rst = 0; game_en = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_pickup_cycle();
    test_cooldown_pickup();
`ifdef SHIELD_EXTEND_EN
    test_extend();
`endif
    test_grace();
    test_blink();
    test_game_en_drop();
    test_rst_cooldown();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
